// File: rtl/uart_pkg.sv
// Shared types and header framing for the UART word scheduler and its receive-side decoder.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_e;

  localparam int unsigned BITS_PER_WORD_DEF = 8;
  localparam logic [3:0]  HDR_TAG_DEF       = 4'hA;

  // Header byte: tag in the upper nibble, source id in the lower nibble.
  function automatic logic [7:0] pack_hdr(input logic [3:0] tag, input logic [3:0] id);
    return {tag, id};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant wins, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  input  logic                 enable,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int unsigned IW = $clog2(N);

  logic          w_found;
  logic [IW-1:0] w_k;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    w_k     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_k = IW'((32'(last_grant) + i) % N);
      if (enable && !w_found && req[w_k]) begin
        gnt[w_k] = 1'b1;
        gnt_id   = w_k;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART word serializer between N_SRC requesters: header word, payload words
// LSW first, then an idle gap before the next round-robin grant.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned N_SRC         = 4,
  parameter int unsigned W_IN          = 16,
  parameter int unsigned BITS_PER_WORD = BITS_PER_WORD_DEF,
  parameter logic [3:0]  HDR_TAG       = HDR_TAG_DEF,
  parameter int unsigned GAP_CLOCKS    = 40
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_SRC-1:0]             s_valid,
  output logic [N_SRC-1:0]             s_ready,
  input  logic [N_SRC*W_IN-1:0]        s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [BITS_PER_WORD-1:0]     m_data,
  output logic                         m_last,
  output logic [$clog2(N_SRC)-1:0]     grant_id,
  output logic                         busy
);

  localparam int unsigned NUM_WORDS = W_IN / BITS_PER_WORD;
  localparam int unsigned IW        = $clog2(N_SRC);
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned CW        = (GAP_CLOCKS > 0) ? $clog2(GAP_CLOCKS + 1) : 1;

  state_e            r_state;
  state_e            w_next;
  logic [W_IN-1:0]   r_buf;
  logic [IDX_W-1:0]  r_idx;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_last_grant;
  logic [IW-1:0]     r_grant_id;
  logic [N_SRC-1:0]  w_gnt;
  logic [IW-1:0]     w_gnt_id;
  logic              w_arb_en;
  logic              w_hs;
  logic              w_last_word;

  assign w_arb_en    = (r_state == IDLE);
  assign w_hs        = |w_gnt;
  assign w_last_word = (r_idx == IDX_W'(NUM_WORDS - 1));
  assign s_ready     = w_gnt;
  assign grant_id    = r_grant_id;

  rr_arbiter #(.N(N_SRC)) u_arb (
    .req        (s_valid),
    .last_grant (r_last_grant),
    .enable     (w_arb_en),
    .gnt        (w_gnt),
    .gnt_id     (w_gnt_id)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_hs) w_next = HDR;
      HDR:  if (m_ready) w_next = DATA;
      DATA: if (m_ready && w_last_word) w_next = (GAP_CLOCKS == 0) ? IDLE : GAP;
      GAP:  if (r_cnt <= CW'(1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Word outputs are pure decodes of registered state, so they hold under backpressure.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_last  = 1'b0;
    busy    = (r_state != IDLE);
    case (r_state)
      HDR: begin
        m_valid = 1'b1;
        m_data  = BITS_PER_WORD'(pack_hdr(HDR_TAG, 4'(r_grant_id)));
      end
      DATA: begin
        m_valid = 1'b1;
        m_data  = BITS_PER_WORD'(r_buf >> (32'(r_idx) * BITS_PER_WORD));
        m_last  = w_last_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_last_grant <= IW'(N_SRC - 1);
      r_grant_id   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          r_buf        <= W_IN'(s_data >> (32'(w_gnt_id) * W_IN));
          r_grant_id   <= w_gnt_id;
          r_last_grant <= w_gnt_id;
        end
        HDR: if (m_ready) r_idx <= '0;
        DATA: if (m_ready) begin
          if (w_last_word) begin
            r_idx <= '0;
            r_cnt <= CW'(GAP_CLOCKS);
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        GAP: if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (default gap DUT plus a zero-gap DUT).
module tb_uart_tx_scheduler;

  logic        clk;
  logic        rstn;
  logic [3:0]  s_valid;
  logic [3:0]  s_ready;
  logic [63:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic [1:0]  grant_id;
  logic        busy;

  logic [3:0]  g_s_valid;
  logic [3:0]  g_s_ready;
  logic [63:0] g_s_data;
  logic        g_m_valid;
  logic        g_m_ready;
  logic [7:0]  g_m_data;
  logic        g_m_last;
  logic [1:0]  g_grant_id;
  logic        g_busy;

  int n_checks;
  int n_fail;

  uart_tx_scheduler #(.N_SRC(4), .W_IN(16), .BITS_PER_WORD(8), .HDR_TAG(4'hA), .GAP_CLOCKS(40)) dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .grant_id(grant_id), .busy(busy)
  );

  uart_tx_scheduler #(.N_SRC(4), .W_IN(16), .BITS_PER_WORD(8), .HDR_TAG(4'hA), .GAP_CLOCKS(0)) dut_g0 (
    .clk(clk), .rstn(rstn), .s_valid(g_s_valid), .s_ready(g_s_ready), .s_data(g_s_data),
    .m_valid(g_m_valid), .m_ready(g_m_ready), .m_data(g_m_data), .m_last(g_m_last),
    .grant_id(g_grant_id), .busy(g_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, then sample.
  task automatic tick(input logic rdy, input logic [3:0] clr_m, input logic [3:0] set_m);
    @(negedge clk);
    m_ready = rdy;
    s_valid = (s_valid & ~clr_m) | set_m;
    #1;
  endtask

  // Wait for IDLE, expect the grant there, then accept n_words words and check them.
  task automatic run_msg(input int exp_id, input logic [15:0] payload, input int unsigned pct,
                         input logic drop, input int n_words,
                         input logic [3:0] clr_m, input logic [3:0] set_m);
    logic [7:0] ew [3];
    logic       rdy;
    logic       held;
    logic [7:0] h_data;
    logic       h_last;
    int         k;
    bit         idle_seen;
    ew[0] = {4'hA, 4'(exp_id)};
    ew[1] = payload[7:0];
    ew[2] = payload[15:8];
    idle_seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick(1'b1, (c == 0) ? clr_m : 4'b0, (c == 0) ? set_m : 4'b0);
      if (!busy) begin
        idle_seen = 1'b1;
        break;
      end
      check("sready_while_busy", 32'(s_ready), 32'd0);
    end
    if (!idle_seen) check("idle_timeout", 32'd0, 32'd1);
    check("grant_onehot", 32'(s_ready), 32'(4'b1 << exp_id));
    k = 0;
    held = 1'b0;
    h_data = '0;
    h_last = 1'b0;
    for (int c = 0; c < 400 && k < n_words; c++) begin
      rdy = ($urandom_range(99) < pct);
      tick(rdy, (c == 0 && drop) ? 4'(4'b1 << exp_id) : 4'b0, 4'b0);
      check("m_valid", 32'(m_valid), 32'd1);
      if (held) begin
        check("hold_data", 32'(m_data), 32'(h_data));
        check("hold_last", 32'(m_last), 32'(h_last));
      end
      if (rdy) begin
        check("word", 32'(m_data), 32'(ew[k]));
        check("last", 32'(m_last), 32'(k == 2));
        check("grant_id", 32'(grant_id), 32'(exp_id));
        k++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        h_data = m_data;
        h_last = m_last;
      end
    end
    if (k != n_words) check("word_timeout", 32'(k), 32'(n_words));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap_n;
    n_checks  = 0;
    n_fail    = 0;
    rstn      = 1'b0;
    s_valid   = '0;
    s_data    = '0;
    m_ready   = 1'b0;
    g_s_valid = '0;
    g_s_data  = '0;
    g_m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Zero-gap DUT: second grant in the cycle right after the m_last handshake.
    @(negedge clk);
    g_s_data  = 64'h0000_0000_2211_C3B4;
    g_s_valid = 4'b0011;
    #1;
    check("g0_grant0", 32'(g_s_ready), 32'h1);
    @(negedge clk); #1;
    check("g0_hdr", 32'(g_m_data), 32'hA0);
    @(negedge clk); #1;
    check("g0_w0", 32'(g_m_data), 32'hB4);
    @(negedge clk); #1;
    check("g0_last", 32'(g_m_last), 32'd1);
    check("g0_w1", 32'(g_m_data), 32'hC3);
    @(negedge clk); #1;
    check("g0_grant1", 32'(g_s_ready), 32'h2);
    check("g0_busy", 32'(g_busy), 32'd0);
    @(negedge clk);
    g_s_valid = '0;

    // Single source 2 sends BEEF, then a 40-clock gap.
    s_data[32 +: 16] = 16'hBEEF;
    run_msg(2, 16'hBEEF, 100, 1'b1, 3, 4'b0, 4'b0100);
    gap_n = 0;
    for (int c = 0; c < 200; c++) begin
      tick(1'b1, 4'b0, 4'b0);
      if (!busy) break;
      if (m_valid) check("gap_m_valid", 32'(m_valid), 32'd0);
      gap_n++;
    end
    check("gap_len", 32'(gap_n), 32'd40);

    // Contention from reset: 0,1,2,3,0.
    @(negedge clk); rstn = 1'b0;
    s_data = 64'h4433_3322_2211_1100;
    @(negedge clk); rstn = 1'b1;
    run_msg(0, 16'h1100, 100, 1'b0, 3, 4'b0, 4'b1111);
    run_msg(1, 16'h2211, 100, 1'b0, 3, 4'b0, 4'b0);
    run_msg(2, 16'h3322, 100, 1'b0, 3, 4'b0, 4'b0);
    run_msg(3, 16'h4433, 100, 1'b0, 3, 4'b0, 4'b0);
    run_msg(0, 16'h1100, 100, 1'b0, 3, 4'b0, 4'b0);
    tick(1'b1, 4'b1111, 4'b0);

    // Backpressure at 30% ready.
    s_data[16 +: 16] = 16'h1234;
    s_data[48 +: 16] = 16'hCAFE;
    run_msg(1, 16'h1234, 30, 1'b1, 3, 4'b0, 4'b0010);
    run_msg(3, 16'hCAFE, 30, 1'b1, 3, 4'b0, 4'b1000);

    // Reset mid-DATA after the first payload word.
    s_data[16 +: 16] = 16'h5678;
    run_msg(1, 16'h5678, 100, 1'b1, 2, 4'b0, 4'b0010);
    @(negedge clk);
    s_valid = '0;
    rstn    = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_m_data", 32'(m_data), 32'd0);
    check("mid_rst_m_last", 32'(m_last), 32'd0);
    check("mid_rst_grant_id", 32'(grant_id), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk); rstn = 1'b1;
    s_data[0 +: 16]  = 16'h0F0F;
    s_data[16 +: 16] = 16'h9999;
    run_msg(0, 16'h0F0F, 100, 1'b1, 3, 4'b0, 4'b0011);
    run_msg(1, 16'h9999, 100, 1'b1, 3, 4'b0, 4'b0);

    // Late request from source 3 raised during the gap.
    repeat (5) tick(1'b1, 4'b0, 4'b0);
    s_data[48 +: 16] = 16'h3333;
    run_msg(3, 16'h3333, 100, 1'b1, 3, 4'b0, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
